// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared cache datapath types, including the memory burst geometry
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  localparam int BURST_W = 64;
  localparam int BURSTS  = 4;
  localparam int LINE_W  = 256;

  typedef logic [LINE_W-1:0] cacheline_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - converts 256-bit cache line fills/writebacks into memory bursts
// Optional beat timeout enabled by CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
  import rv32i_types::cacheline_t;
  import rv32i_types::rv32i_word;
#(
  parameter int BURST_W = rv32i_types::BURST_W,
  parameter int BURSTS  = rv32i_types::BURSTS
) (
  input  logic                clk,
  input  logic                rst,
  input  rv32i_word           address_i,
  input  cacheline_t          line_i,
  input  logic                read_i,
  input  logic                write_i,
  output cacheline_t          line_o,
  output logic                resp_o,
  output logic                err_o,
  input  logic [BURST_W-1:0]  burst_i,
  output logic [BURST_W-1:0]  burst_o,
  output rv32i_word           address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam int CW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURSTS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cacheline_t line_q, line_d;
  cacheline_t wline_q, wline_d;
  rv32i_word  addr_q, addr_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [7:0] idle_q, idle_d;
  logic       err_q, err_d;
  logic       timeout;
  assign timeout = (idle_q == 8'd254) && !resp_i;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      wline_q <= '0;
      addr_q  <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      idle_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      wline_q <= wline_d;
      addr_q  <= addr_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      idle_q  <= idle_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    wline_d = wline_q;
    addr_d  = addr_q;
    resp_o  = 1'b0;
    read_o  = 1'b0;
    write_o = 1'b0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    err_d   = err_q;
    idle_d  = idle_q;
    if (state_q == IDLE || resp_i) begin
      idle_d = '0;
    end else if (state_q == READ || state_q == WRITE) begin
      idle_d = idle_q + 8'd1;
    end
`endif
    case (state_q)
      IDLE: begin
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        err_d = 1'b0;
`endif
        // write wins over read so a dirty victim is flushed before its refill
        if (write_i) begin
          state_d = WRITE;
          wline_d = line_i;
          addr_d  = {address_i[31:5], 5'b0};
          cnt_d   = '0;
        end else if (read_i) begin
          state_d = READ;
          addr_d  = {address_i[31:5], 5'b0};
          cnt_d   = '0;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
`endif
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        else if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
`endif
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  assign err_o = resp_o & err_q;
`else
  assign err_o = 1'b0;
`endif

  assign burst_o   = wline_q[int'(cnt_q)*BURST_W +: BURST_W];
  assign line_o    = line_q;
  assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic         err_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_vec = 0;
  int n_err = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .err_o     (err_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input logic [255:0] line, input int gap);
    read_i    = 1'b1;
    address_i = addr;
    tick();
    read_i    = 1'b0;
    address_i = 32'hFFFF_FFFF;
    chk("fill_read_o", read_o, 1);
    chk("fill_write_o", write_o, 0);
    chk("fill_addr", address_o, {addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i  = 1'b0;
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        chk("fill_stall_resp", resp_o, 0);
        chk("fill_stall_read_o", read_o, 1);
      end
      resp_i  = 1'b1;
      burst_i = line[b*64 +: 64];
      tick();
    end
    resp_i = 1'b0;
    chk("fill_resp", resp_o, 1);
    chk("fill_err", err_o, 0);
    chk("fill_line", line_o, line);
    chk("fill_done_read_o", read_o, 0);
    tick();
    chk("fill_resp_drop", resp_o, 0);
  endtask

  task automatic wb(input logic [31:0] addr, input logic [255:0] line, input int gap,
                    input logic with_read);
    write_i   = 1'b1;
    read_i    = with_read;
    line_i    = line;
    address_i = addr;
    tick();
    write_i   = 1'b0;
    read_i    = 1'b0;
    line_i    = '0;
    chk("wb_write_o", write_o, 1);
    chk("wb_read_o", read_o, 0);
    chk("wb_addr", address_o, {addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        resp_i = 1'b0;
        tick();
        chk("wb_stall_resp", resp_o, 0);
      end
      resp_i = 1'b1;
      #1;
      chk("wb_burst", burst_o, line[b*64 +: 64]);
      tick();
    end
    resp_i = 1'b0;
    chk("wb_resp", resp_o, 1);
    chk("wb_err", err_o, 0);
    chk("wb_done_write_o", write_o, 0);
    tick();
    chk("wb_resp_drop", resp_o, 0);
  endtask

  logic [255:0] l1, l2, l3, wl, saw_resp;

  initial begin
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
          64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE};
    wl = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
          64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    #3;
    chk("rst_resp", resp_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_line", line_o, 0);
    tick();
    rst = 1'b1;
    tick();

    fill(32'h1234_5678, l1, 0);
    chk("fill_addr_value", address_o, 32'h1234_5660);
    wb(32'h0000_0040, wl, 0, 1'b0);
    chk("line_held_after_wb", line_o, l1);
    fill(32'hABCD_EF1F, l2, 3);
    wb(32'h8000_003F, wl, 2, 1'b1);

    // resp_i while idle must not start or complete anything
    resp_i = 1'b1;
    tick();
    chk("idle_resp_ignored", resp_o, 0);
    chk("idle_read_o", read_o, 0);
    resp_i = 1'b0;

    // reset after two beats abandons the fill
    read_i = 1'b1; address_i = 32'h0000_1000;
    tick();
    read_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
      tick();
    end
    rst = 1'b0;
    #2;
    chk("midrst_read_o", read_o, 0);
    chk("midrst_resp", resp_o, 0);
    chk("midrst_addr", address_o, 0);
    chk("midrst_line", line_o, 0);
    tick();
    rst = 1'b1;
    saw_resp = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_o) saw_resp = 1;
    end
    resp_i = 1'b0;
    chk("midrst_no_resp", saw_resp, 0);
    l3 = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
          64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
    fill(32'h0000_1000, l3, 1);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    read_i = 1'b0; resp_i = 1'b0;
    for (int i = 0; i < 254; i++) tick();
    chk("to_cycle255_resp", resp_o, 0);
    chk("to_cycle255_read_o", read_o, 1);
    tick();
    chk("to_resp", resp_o, 1);
    chk("to_err", err_o, 1);
    chk("to_read_o", read_o, 0);
    tick();
    chk("to_resp_drop", resp_o, 0);
    chk("to_err_drop", err_o, 0);
    fill(32'h0000_3000, l1, 0);
`else
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick();
    read_i = 1'b0; resp_i = 1'b0;
    saw_resp = '0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (resp_o || err_o) saw_resp = 1;
    end
    chk("no_timeout_resp", saw_resp, 0);
    chk("no_timeout_read_o", read_o, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    fill(32'h0000_3000, l1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL take parameter BURST_W, default 64, as the width of one memory beat.
REQ-002 SHALL take parameter BURSTS, default 4, as the beats per line; BURST_W*BURSTS SHALL equal 256.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 address_i  input  32  line address from the cache.
REQ-007 line_i  input  256  line to write back.
REQ-008 read_i / write_i  input  1 each  line fill / writeback request from the cache.
REQ-009 line_o  output  256  assembled fill line.
REQ-010 resp_o  output  1  one-cycle completion strobe to the cache.
REQ-011 err_o  output  1  timeout flag, qualified by resp_o.
REQ-012 burst_i  input  BURST_W  read beat from memory.
REQ-013 burst_o  output  BURST_W  write beat to memory.
REQ-014 address_o  output  32  memory address.
REQ-015 read_o / write_o  output  1 each  memory burst request.
REQ-016 resp_i  input  1  memory beat accept/valid.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE and DONE.
REQ-018 IDLE: write_i=1 -> WRITE, capture line_i; else read_i=1 -> READ. write_i SHALL win when both are high.
REQ-019 On leaving IDLE, address_o SHALL latch {address_i[31:5],5'b0} and hold until DONE.
REQ-020 read_o SHALL be 1 in READ only; write_o SHALL be 1 in WRITE only.
REQ-021 An internal beat counter SHALL clear on IDLE exit.
REQ-022 The counter SHALL advance once per cycle with resp_i=1.
REQ-023 READ: each resp_i beat SHALL store burst_i into line slot [count*BURST_W +: BURST_W]; beat 0 = bits 63:0.
REQ-024 WRITE: burst_o SHALL present slot [count] of the captured line, combinationally from the counter.
REQ-025 The beat with count = BURSTS-1 and resp_i=1 SHALL move the FSM to DONE.
REQ-026 DONE SHALL assert resp_o for exactly one cycle, then return to IDLE.
REQ-027 Request sampled at edge N with memory responding every cycle -> resp_o high in cycle N+BURSTS+1.
REQ-028 line_o SHALL hold the last completed fill until the next READ beat 0.
REQ-029 resp_i SHALL be ignored in IDLE and DONE.
REQ-030 read_i/write_i SHALL be ignored outside IDLE.
REQ-031 A request held high through DONE SHALL start a new transaction; deassertion is the cache's duty.
REQ-032 err_o SHALL be 0 whenever resp_o=0.

Reset
REQ-033 rst low SHALL force IDLE and zero the counter, line buffers and address_o.
REQ-034 rst low SHALL drive resp_o, err_o, read_o and write_o to 0, with no clock needed.
REQ-035 Reset mid-burst SHALL abandon the transaction; no resp_o SHALL follow.

Configuration
REQ-036 The macro SHALL be CACHELINE_ADAPTOR_TIMEOUT_EN.
REQ-037 With the macro, an 8-bit idle counter SHALL clear on each resp_i and in IDLE.
REQ-038 With the macro, 255 consecutive READ/WRITE cycles without resp_i SHALL force DONE with err_o=1.
REQ-039 With the macro, read_o/write_o SHALL drop in that DONE cycle.
REQ-040 Without the macro, err_o SHALL be tied 0 and the FSM SHALL wait indefinitely.

Structure
REQ-041 BURST_W, BURSTS and a 256-bit line typedef SHALL live in rv32i_types beside the cache datapath types.
REQ-042 The FSM state enum SHALL stay local to the module.
REQ-043 No sub-module SHALL be instantiated; the design SHALL be a single FSM plus line registers.

Verification
REQ-044 Fill: read_i, address_i=0x1234_5678, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x1234_5660, line_o={44..,33..,22..,11..}, one resp_o pulse, err_o=0.
REQ-045 Writeback: write_i, line_i={D,C,B,A} -> burst_o=A,B,C,D in order on each resp_i, then one resp_o.
REQ-046 Stall: resp_i gaps of 3 cycles between beats -> beats not skipped or duplicated; resp_o only after the 4th beat.
REQ-047 Simultaneous read_i=write_i=1 -> WRITE taken, write_o=1, read_o=0.
REQ-048 rst low after beat 2 -> outputs 0 immediately, no resp_o; the next fill completes correctly.
REQ-049 With CACHELINE_ADAPTOR_TIMEOUT_EN and no resp_i -> resp_o=err_o=1 at cycle 256 after entering READ.
